reqresp_tpg: RTL
================

# reqresp_tpg

Closed-loop request generator that sits directly upstream of a dependency via on the NoC: it injects request flits carrying its own return address, then consumes the via's replies. Caps outstanding requests, checks each reply's destination and sequence, and measures round-trip latency through an internal FIFO of send timestamps. Used as the traffic source that drives via-based simulation models and ends the run through `done`.

## Interface
- `N`, 16, number of NoC nodes
- `NUM_VC`, 2, number of VCs
- `N_ADDR_WIDTH`, $clog2(N), node address width
- `VC_ADDR_WIDTH`, $clog2(NUM_VC), VC address width
- `o0_WIDTH`, 32, request flit width
- `i0_WIDTH`, 32, reply flit width
- `o0_ID`, 0, 8-bit source id placed in requests
- `o0_NODE`, 0, router this source is attached to
- `i0_NODE`, 0, router this sink is attached to (used as return address)
- `i0_VC`, 0, VC replies must arrive on (used as return VC)
- `o0_DEST`, 15, router of the downstream via
- `o0_VC`, 0, VC used toward the via
- `MAX_OUTSTANDING`, 4, request credit limit (power of 2, ≥1)
- `NUM_TESTS`, 1000, requests to send before stopping
- `clk` in 1 — clock; all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `done` out 1 — NUM_TESTS sent and all replied
- `o0_data_out` out o0_WIDTH — {i0_NODE, i0_VC, o0_NODE, o0_DEST, o0_VC, o0_ID, seq}
- `o0_dest_out` out N_ADDR_WIDTH — always o0_DEST
- `o0_vc_out` out VC_ADDR_WIDTH — always o0_VC
- `o0_valid_out` out 1 — one-cycle pulse per request
- `o0_ready_in` in 1 — NoC can accept
- `i0_data_in` in i0_WIDTH — reply flit, same field layout
- `i0_valid_in` in 1 — reply valid
- `i0_ready_out` out 1 — reply accept
- `outstanding` out $clog2(MAX_OUTSTANDING+1) — requests awaiting reply
- `err_count` out 16 — saturating error count
- `lat_sum` out 32 — saturating sum of round-trip latencies
- `lat_max` out 32 — largest round-trip latency seen

## Operation
- Field layout, MSB first: return node (NA), return VC (VA), src (NA), dst (NA), vc (VA), id (8), seq (CW = width − 3·NA − 2·VA − 8).
- Free-running 32-bit `cyc` counter, cleared by reset, wraps.
- Issue condition at a clock edge: `o0_ready_in` && outstanding < MAX_OUTSTANDING && sent < NUM_TESTS. If met: seq increments (first request seq = 1), `o0_valid_out` registers 1, `cyc` pushed to timestamp FIFO, sent++ and outstanding++. Otherwise `o0_valid_out` registers 0. Each high cycle of valid is exactly one accepted request.
- `i0_ready_out` registers 1 every cycle after reset (FIFO can never overflow because of the credit cap).
- Reply accept: `i0_valid_in && i0_ready_out`. On accept with outstanding > 0: pop FIFO, latency = `cyc` − popped timestamp (mod 2^32), add to `lat_sum` (saturate at 0xFFFFFFFF), update `lat_max`, outstanding--.
- Reply checks, each failure increments `err_count` by 1 (saturate at 0xFFFF; two failures in one flit add 2): dst field ≠ i0_NODE; vc field ≠ i0_VC; seq ≠ expected (expected starts at 1, then becomes received seq + 1 regardless of mismatch).
- Reply with outstanding == 0: unsolicited; `err_count` +1, no pop, no latency update, outstanding stays 0, no other checks.
- Same-cycle issue and accept: outstanding unchanged, FIFO push and pop both occur (pop reads entry before push when FIFO count is 1 or more).
- `done` = sent == NUM_TESTS && outstanding == 0; once set stays set until reset.

## Timing
- Reset values: `o0_valid_out`=0, `i0_ready_out`=0, `done`=0, `outstanding`=0, `err_count`=0, `lat_sum`=0, `lat_max`=0, `o0_data_out` seq field 0; `o0_dest_out`/`o0_vc_out` constant.
- Reset mid-run: FIFO emptied, all counters cleared, in-flight replies arriving after reset count as unsolicited.
- Issue decision at edge k → `o0_valid_out` high during cycle k+1 only.
- First `i0_ready_out`=1 one cycle after `rst` deasserts.
- Latency counted from issue edge to accept edge; minimum measurable latency 1.
- Sustained issue rate 1/cycle while credits and `o0_ready_in` allow.

## Test plan
- Loopback bench (reply = request with dst swapped to i0_NODE, seq echoed, 3-cycle delay), NUM_TESTS=8 → 8 valid pulses, `lat_sum`=24, `lat_max`=3, `err_count`=0, `done`=1.
- No replies, MAX_OUTSTANDING=4, ready held high → exactly 4 valid pulses, `outstanding`=4, `done`=0.
- `o0_ready_in` toggling 1,0,1,0 → requests only on ready-high edges, seq 1,2,3 contiguous.
- Reply with wrong dst and seq gap (expects 2, gets 5) → `err_count`=2 from that flit; next seq 6 error-free.
- Unsolicited reply after reset → `err_count`=1, `outstanding` stays 0.
- Reset asserted with 3 outstanding → all outputs return to reset values next cycle; run then completes normally.

Source files
------------

// File: rtl/reqresp_tpg_if.sv
// Request/reply handshake bundle between the traffic generator and the NoC.
// master: generator side (drives requests, accepts replies); slave: NoC side.
interface reqresp_tpg_if #(
    parameter int N_ADDR_WIDTH  = 4,
    parameter int VC_ADDR_WIDTH = 1,
    parameter int o0_WIDTH      = 32,
    parameter int i0_WIDTH      = 32
);
    logic [o0_WIDTH-1:0]      o0_data_out;
    logic [N_ADDR_WIDTH-1:0]  o0_dest_out;
    logic [VC_ADDR_WIDTH-1:0] o0_vc_out;
    logic                     o0_valid_out;
    logic                     o0_ready_in;
    logic [i0_WIDTH-1:0]      i0_data_in;
    logic                     i0_valid_in;
    logic                     i0_ready_out;

    modport master (
        output o0_data_out, o0_dest_out, o0_vc_out, o0_valid_out,
        output i0_ready_out,
        input  o0_ready_in, i0_data_in, i0_valid_in
    );

    modport slave (
        input  o0_data_out, o0_dest_out, o0_vc_out, o0_valid_out,
        input  i0_ready_out,
        output o0_ready_in, i0_data_in, i0_valid_in
    );
endinterface

// File: rtl/reqresp_tpg.sv
// Closed-loop request generator: issues credited requests, checks replies
// and measures round-trip latency. Ports: clk, rst, bus (master), status.
module reqresp_tpg #(
    parameter int N               = 16,
    parameter int NUM_VC          = 2,
    parameter int N_ADDR_WIDTH    = $clog2(N),
    parameter int VC_ADDR_WIDTH   = $clog2(NUM_VC),
    parameter int o0_WIDTH        = 32,
    parameter int i0_WIDTH        = 32,
    parameter int o0_ID           = 0,
    parameter int o0_NODE         = 0,
    parameter int i0_NODE         = 0,
    parameter int i0_VC           = 0,
    parameter int o0_DEST         = 15,
    parameter int o0_VC           = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int NUM_TESTS       = 1000,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic           clk,
    input  logic           rst,
    reqresp_tpg_if.master  bus,
    output logic           done,
    output logic [OW-1:0]  outstanding,
    output logic [15:0]    err_count,
    output logic [31:0]    lat_sum,
    output logic [31:0]    lat_max
);
    localparam int NA = N_ADDR_WIDTH;
    localparam int VA = VC_ADDR_WIDTH;
    localparam int CW = o0_WIDTH - 3 * NA - 2 * VA - 8;
    localparam int RW = i0_WIDTH - 3 * NA - 2 * VA - 8;
    localparam int SW = $clog2(NUM_TESTS + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int VC_LSB  = RW + 8;
    localparam int DST_LSB = VC_LSB + VA;
    localparam int HI_LSB  = DST_LSB + NA;

    localparam logic [OW-1:0] MAX_C  = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] NT_C   = SW'(NUM_TESTS);
    localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   cyc;
    logic [CW-1:0] seq;
    logic [RW-1:0] exp_seq;
    logic [SW-1:0] sent;
    logic          valid_q;
    logic          iready_q;

    // Send timestamps; depth equals the credit limit so it cannot overflow.
    logic [31:0]   ts_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          issue;
    logic          accept;
    logic          pop;
    logic          unsol;
    logic          dst_bad;
    logic          vc_bad;
    logic          seq_bad;
    logic [1:0]    err_inc;
    logic [RW-1:0] rx_seq;
    logic [31:0]   lat;
    logic [32:0]   sum_ext;
    logic [16:0]   err_ext;
    logic [OW-1:0] out_n;
    logic [SW-1:0] sent_n;
    logic          unused_rx;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    assign rx_seq  = bus.i0_data_in[RW-1:0];
    assign dst_bad = bus.i0_data_in[DST_LSB +: NA] != NA'(i0_NODE);
    assign vc_bad  = bus.i0_data_in[VC_LSB +: VA] != VA'(i0_VC);
    assign seq_bad = rx_seq != exp_seq;

    assign unused_rx = ^{bus.i0_data_in[i0_WIDTH-1:HI_LSB],
                         bus.i0_data_in[VC_LSB-1:RW]};

    always_comb begin
        issue   = bus.o0_ready_in && (outstanding < MAX_C) && (sent < NT_C);
        accept  = bus.i0_valid_in && iready_q;
        pop     = accept && (outstanding != '0);
        unsol   = accept && (outstanding == '0);
        err_inc = '0;
        if (unsol) begin
            err_inc = 2'd1;
        end else if (pop) begin
            err_inc = 2'(dst_bad) + 2'(vc_bad) + 2'(seq_bad);
        end
        out_n   = outstanding + OW'(issue) - OW'(pop);
        sent_n  = sent + SW'(issue);
        // Pop reads the oldest entry before any same-edge push lands.
        lat     = cyc - ts_mem[rd_ptr];
        sum_ext = {1'b0, lat_sum} + {1'b0, lat};
        err_ext = {1'b0, err_count} + 17'(err_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc         <= '0;
            seq         <= '0;
            exp_seq     <= RW'(1);
            sent        <= '0;
            valid_q     <= 1'b0;
            iready_q    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err_count   <= '0;
            lat_sum     <= '0;
            lat_max     <= '0;
            done        <= 1'b0;
        end else begin
            cyc         <= cyc + 32'd1;
            valid_q     <= issue;
            iready_q    <= 1'b1;
            outstanding <= out_n;
            sent        <= sent_n;
            err_count   <= err_ext[16] ? '1 : err_ext[15:0];
            done        <= done | ((sent_n == NT_C) && (out_n == '0));
            if (issue) begin
                seq    <= seq + CW'(1);
                wr_ptr <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= nxt(rd_ptr);
                exp_seq <= rx_seq + RW'(1);
                lat_sum <= sum_ext[32] ? '1 : sum_ext[31:0];
                if (lat > lat_max) begin
                    lat_max <= lat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            ts_mem[wr_ptr] <= cyc;
        end
    end

    assign bus.o0_data_out  = {NA'(i0_NODE), VA'(i0_VC), NA'(o0_NODE),
                               NA'(o0_DEST), VA'(o0_VC), 8'(o0_ID), seq};
    assign bus.o0_dest_out  = NA'(o0_DEST);
    assign bus.o0_vc_out    = VA'(o0_VC);
    assign bus.o0_valid_out = valid_q;
    assign bus.i0_ready_out = iready_q;
endmodule
